fpcvt_seq: RTL

FPCVT_SEQ -- requirements
Module: fpcvt_seq

---
 rtl/fpcvt_pkg.sv | 10 +
 rtl/fpcvt_round.sv | 29 ++
 rtl/fpcvt_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared widths, limits and FSM state encoding for the fixed-to-float converter
package fpcvt_pkg;
   localparam int D_W = 12;
   localparam int E_W = 3;
   localparam int F_W = 4;
   localparam int M_W = D_W - 1;
   localparam logic [E_W-1:0] E_MAX = 3'd7;
   localparam logic [F_W-1:0] F_MAX = 4'd15;
   typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fpcvt_round.sv
// fpcvt_round: rounds the normalised magnitude to 4 significand bits and clamps exponent overflow
module fpcvt_round
   import fpcvt_pkg::*;
(
   input  logic [4:0]     mag_i,
   input  logic [E_W-1:0] e_i,
   output logic [E_W-1:0] e_o,
   output logic [F_W-1:0] f_o,
   output logic           ovf_o
);
   logic [F_W:0] f_inc;
   assign f_inc = {1'b0, mag_i[4:1]} + {4'd0, mag_i[0]};
   // round half-up; a significand carry renormalises to 8 and bumps E, saturating at the top
   always_comb begin
      e_o   = e_i;
      f_o   = mag_i[4:1];
      ovf_o = 1'b0;
      if (e_i != '0) begin
         if (!f_inc[F_W]) f_o = f_inc[F_W-1:0];
         else if (e_i == E_MAX) begin
            f_o   = F_MAX;
            ovf_o = 1'b1;
         end else begin
            f_o = 4'd8;
            e_o = e_i + 3'd1;
         end
      end
   end
endmodule

// File: rtl/fpcvt_seq.sv
// fpcvt_seq: sequential 12-bit two's-complement to sign/3-bit exponent/4-bit significand converter; FPCVT_SEQ_FLAGS_EN adds a flags port
module fpcvt_seq
   import fpcvt_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [D_W-1:0] in_d,
   output logic           in_ready,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_s,
   output logic [E_W-1:0] out_e,
   output logic [F_W-1:0] out_f,
   output logic           busy
`ifdef FPCVT_SEQ_FLAGS_EN
   ,
   output logic [1:0]     flags
`endif
);
   state_t         state_q, state_d;
   logic [D_W-1:0] raw_q, raw_d;
   logic [M_W-1:0] mag_q, mag_d;
   logic [E_W-1:0] exp_q, exp_d, e_q, e_d, r_e;
   logic [F_W-1:0] f_q, f_d, r_f;
   logic           s_q, s_d, ovf;

   fpcvt_round u_round (
      .mag_i (mag_q[M_W-1:M_W-5]),
      .e_i   (exp_q),
      .e_o   (r_e),
      .f_o   (r_f),
      .ovf_o (ovf)
   );

   assign in_ready  = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign out_valid = state_q == DONE;
   assign out_s     = s_q;
   assign out_e     = e_q;
   assign out_f     = f_q;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end

   // datapath registers; outputs only load on the ROUND->DONE transition
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q <= '0;
         mag_q <= '0;
         exp_q <= '0;
         s_q   <= 1'b0;
         e_q   <= '0;
         f_q   <= '0;
      end else begin
         raw_q <= raw_d;
         mag_q <= mag_d;
         exp_q <= exp_d;
         s_q   <= s_d;
         e_q   <= e_d;
         f_q   <= f_d;
      end
   end

   // next state: capture, magnitude, normalise one bit per cycle, round, hold result
   always_comb begin
      state_d = state_q;
      raw_d   = raw_q;
      mag_d   = mag_q;
      exp_d   = exp_q;
      s_d     = s_q;
      e_d     = e_q;
      f_d     = f_q;
      case (state_q)
         IDLE: if (in_valid) begin
            raw_d   = in_d;
            state_d = ABS;
         end
         ABS: begin
            mag_d   = (raw_q == 12'h800) ? 11'h7FF : raw_q[D_W-1] ? ~raw_q[M_W-1:0] + 11'd1 : raw_q[M_W-1:0];
            exp_d   = E_MAX;
            state_d = NORM;
         end
         NORM: if (mag_q[M_W-1] || exp_q == '0) state_d = ROUND;
         else begin
            mag_d = {mag_q[M_W-2:0], 1'b0};
            exp_d = exp_q - 3'd1;
         end
         ROUND: begin
            s_d     = raw_q[D_W-1];
            e_d     = r_e;
            f_d     = r_f;
            state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef FPCVT_SEQ_FLAGS_EN
   logic [1:0] flags_q;
   assign flags = flags_q;
   // flags[0]: input was -2048, flags[1]: exponent clamp; captured alongside the result
   always_ff @(posedge clk) begin
      if (rst) flags_q <= '0;
      else if (state_q == ROUND) flags_q <= {ovf, raw_q == 12'h800};
   end
`else
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif
endmodule
